// File: rtl/timer_bank.sv
// Multi-channel interval timer bank: shared prescaled tick, per-channel IDLE/RUN/PAUSE/DONE FSM.
// Define TIMER_TICK_BYPASS_EN to drop the prescaler so every clock is a tick.
module timer_bank #(
  parameter int WIDTH    = 12,
  parameter int NUM_CH   = 2,
  parameter int PRESCALE = 25000,
  parameter int PS_W     = 15
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_CH-1:0]         i_Start,
  input  logic [NUM_CH-1:0]         i_Stop,
  input  logic [NUM_CH-1:0]         i_Clear,
  input  logic [NUM_CH-1:0]         i_Reload,
  input  logic [NUM_CH*WIDTH-1:0]   i_Limit,
  output logic [NUM_CH*WIDTH-1:0]   o_Count,
  output logic [NUM_CH-1:0]         o_Running,
  output logic [NUM_CH-1:0]         o_Expired,
  output logic [NUM_CH-1:0]         o_Done,
  output logic                      o_Tick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  logic r_tick;
  logic w_tick;

`ifdef TIMER_TICK_BYPASS_EN
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) r_tick <= 1'b0;
    else          r_tick <= 1'b1;
  end
  assign w_tick = 1'b1;
`else
  logic [PS_W-1:0] r_ps;
  logic            w_ps_wrap;

  assign w_ps_wrap = (r_ps == PS_W'(PRESCALE - 1));

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_ps   <= '0;
      r_tick <= 1'b0;
    end else begin
      r_ps   <= w_ps_wrap ? '0 : r_ps + 1'b1;
      r_tick <= w_ps_wrap;
    end
  end
  assign w_tick = r_tick;
`endif

  assign o_Tick = r_tick;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      state_t           r_state, w_state_nx;
      logic [WIDTH-1:0] r_count, w_count_nx;
      logic [WIDTH-1:0] r_limit, w_limit_nx;
      logic             r_mode, w_mode_nx;
      logic             r_exp, w_exp_nx;
      logic             w_last;

      // Limit 0 expires on the first tick; otherwise expire on the tick that would reach the limit.
      assign w_last = (r_limit == '0) || (r_count == r_limit - 1'b1);

      always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_limit_nx = r_limit;
        w_mode_nx  = r_mode;
        w_exp_nx   = 1'b0;
        if (i_Clear[k]) begin
          w_state_nx = S_IDLE;
          w_count_nx = '0;
        end else if (i_Stop[k] && (r_state == S_RUN)) begin
          w_state_nx = S_PAUSE;
        end else if (i_Start[k] && (r_state != S_RUN)) begin
          w_state_nx = S_RUN;
          if (r_state != S_PAUSE) begin
            w_limit_nx = i_Limit[k*WIDTH +: WIDTH];
            w_mode_nx  = i_Reload[k];
            w_count_nx = '0;
          end
        end else if ((r_state == S_RUN) && w_tick) begin
          if (w_last) begin
            w_exp_nx = 1'b1;
            if (r_mode) begin
              w_count_nx = '0;
            end else begin
              w_count_nx = r_limit;
              w_state_nx = S_DONE;
            end
          end else begin
            w_count_nx = r_count + 1'b1;
          end
        end
      end

      always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_limit <= '0;
          r_mode  <= 1'b0;
          r_exp   <= 1'b0;
        end else begin
          r_state <= w_state_nx;
          r_count <= w_count_nx;
          r_limit <= w_limit_nx;
          r_mode  <= w_mode_nx;
          r_exp   <= w_exp_nx;
        end
      end

      assign o_Count[k*WIDTH +: WIDTH] = r_count;
      assign o_Running[k]              = (r_state == S_RUN);
      assign o_Done[k]                 = (r_state == S_DONE);
      assign o_Expired[k]              = r_exp;
    end
  endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with PRESCALE=4: expiry records queued at stimulus time,
// popped and compared by a monitor whenever o_Expired pulses.
module tb_timer_bank;
  localparam int WIDTH = 12;
  localparam int NUM_CH = 2;
  localparam int PRESCALE = 4;
  localparam int PS_W = 3;
  localparam int RW = 29; // {cycle[15:0], done, count[11:0]}

  logic                    i_Clock;
  logic                    i_Reset;
  logic [NUM_CH-1:0]       i_Start, i_Stop, i_Clear, i_Reload;
  logic [NUM_CH*WIDTH-1:0] i_Limit;
  logic [NUM_CH*WIDTH-1:0] o_Count;
  logic [NUM_CH-1:0]       o_Running, o_Expired, o_Done;
  logic                    o_Tick;

  timer_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .PS_W(PS_W)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(i_Start), .i_Stop(i_Stop),
    .i_Clear(i_Clear), .i_Reload(i_Reload), .i_Limit(i_Limit), .o_Count(o_Count),
    .o_Running(o_Running), .o_Expired(o_Expired), .o_Done(o_Done), .o_Tick(o_Tick)
  );

  // clock / reset-relative cycle counter
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int cyc;
  always @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] rec(input int c, input logic done, input int count);
    logic [15:0] c16;
    logic [11:0] n12;
    c16 = 16'(c);
    n12 = 12'(count);
    return {c16, done, n12};
  endfunction

  // driver tasks
  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 1000) begin
      @(negedge i_Clock);
      n++;
    end
    if (cyc != c) begin
      errors++;
      checks++;
      $display("FAIL wait_cyc: reached %0d expected %0d", cyc, c);
    end
  endtask

  task automatic pulse(input int ch, input logic start, input logic stop, input logic clear,
                       input logic reload, input logic [WIDTH-1:0] limit);
    i_Start[ch]               = start;
    i_Stop[ch]                = stop;
    i_Clear[ch]               = clear;
    i_Reload[ch]              = reload;
    i_Limit[ch*WIDTH +: WIDTH] = limit;
    @(negedge i_Clock);
    i_Start[ch] = 1'b0;
    i_Stop[ch]  = 1'b0;
    i_Clear[ch] = 1'b0;
  endtask

  // monitor: tick cadence every cycle, expiry records on each o_Expired pulse
  always @(negedge i_Clock) begin
    logic [RW-1:0] got, want;
    check("tick", {31'd0, o_Tick}, {31'd0, (cyc != 0 && (cyc % PRESCALE) == 0)});
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (o_Expired[ch]) begin
        got = rec(cyc, o_Done[ch], int'(o_Count[ch*WIDTH +: WIDTH]));
        if (ch == 0 && exp_q0.size() > 0) begin
          want = exp_q0.pop_front();
          check("expiry_ch0", 32'(got), 32'(want));
        end else if (ch == 1 && exp_q1.size() > 0) begin
          want = exp_q1.pop_front();
          check("expiry_ch1", 32'(got), 32'(want));
        end else begin
          check("unexpected_expiry", 32'(ch + 1), 32'd0);
        end
      end
    end
  end

  initial begin
    i_Reset = 1'b0;
    i_Start = '0; i_Stop = '0; i_Clear = '0; i_Reload = '0; i_Limit = '0;
    repeat (2) @(negedge i_Clock);
    check("rst_count", 32'(o_Count), 32'd0);
    check("rst_running", 32'(o_Running), 32'd0);
    check("rst_expired", 32'(o_Expired), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    #2 i_Reset = 1'b1;

    wait_cyc(12);
    check("idle_count", 32'(o_Count), 32'd0);
    check("idle_running", 32'(o_Running), 32'd0);

    // one-shot ch0, limit 3, started on a tick cycle (that tick is not counted)
    wait_cyc(16);
    exp_q0.push_back(rec(29, 1'b1, 3));
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3);
    check("os_run", 32'(o_Running[0]), 32'd1);
    check("os_cnt0", 32'(o_Count[11:0]), 32'd0);
    wait_cyc(21); check("os_cnt1", 32'(o_Count[11:0]), 32'd1);
    wait_cyc(25); check("os_cnt2", 32'(o_Count[11:0]), 32'd2);
    wait_cyc(30);
    check("os_done", 32'(o_Done[0]), 32'd1);
    check("os_hold", 32'(o_Count[11:0]), 32'd3);
    check("os_stopped", 32'(o_Running[0]), 32'd0);
    pulse(0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd3);
    check("clr_done", 32'(o_Done[0]), 32'd0);
    check("clr_cnt", 32'(o_Count[11:0]), 32'd0);

    // auto-reload ch1, limit 2, five periods
    wait_cyc(32);
    exp_q1.push_back(rec(41, 1'b0, 0));
    exp_q1.push_back(rec(49, 1'b0, 0));
    exp_q1.push_back(rec(57, 1'b0, 0));
    exp_q1.push_back(rec(65, 1'b0, 0));
    exp_q1.push_back(rec(73, 1'b0, 0));
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b1, 12'd2);
    wait_cyc(37); check("ar_cnt1", 32'(o_Count[23:12]), 32'd1);
    wait_cyc(76);
    check("ar_running", 32'(o_Running[1]), 32'd1);
    pulse(1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd2);
    check("ar_clr_run", 32'(o_Running[1]), 32'd0);
    check("ar_clr_cnt", 32'(o_Count[23:12]), 32'd0);

    // pause/resume ch0, limit 10; limit change during pause must be ignored
    wait_cyc(81);
    exp_q0.push_back(rec(141, 1'b1, 10));
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd10);
    wait_cyc(97); check("pr_cnt4", 32'(o_Count[11:0]), 32'd4);
    wait_cyc(98);
    pulse(0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd10);
    i_Limit[11:0] = 12'd2;
    wait_cyc(117);
    check("pr_hold", 32'(o_Count[11:0]), 32'd4);
    check("pr_paused", 32'(o_Running[0]), 32'd0);
    wait_cyc(118);
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd2);
    check("pr_resumed", 32'(o_Running[0]), 32'd1);
    wait_cyc(142);
    pulse(0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2);

    // priority: clear+stop+start on an expiring tick
    wait_cyc(144);
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd1);
    wait_cyc(148);
    pulse(1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd1);
    check("pri_run", 32'(o_Running[1]), 32'd0);
    check("pri_cnt", 32'(o_Count[23:12]), 32'd0);
    check("pri_done", 32'(o_Done[1]), 32'd0);
    check("pri_exp", 32'(o_Expired[1]), 32'd0);

    // limit 0 expires on the first tick with count 0
    wait_cyc(150);
    exp_q0.push_back(rec(153, 1'b1, 0));
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
    wait_cyc(154);
    pulse(0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0);

    // asynchronous reset mid-run at count 5
    wait_cyc(156);
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd10);
    wait_cyc(177); check("mr_cnt5", 32'(o_Count[11:0]), 32'd5);
    wait_cyc(178);
    #2 i_Reset = 1'b0;
    #1;
    check("ar_count", 32'(o_Count), 32'd0);
    check("ar_running", 32'(o_Running), 32'd0);
    check("ar_done", 32'(o_Done), 32'd0);
    check("ar_tick", {31'd0, o_Tick}, 32'd0);
    #9 i_Reset = 1'b1;
    repeat (20) @(negedge i_Clock);
    check("post_rst_run", 32'(o_Running), 32'd0);
    check("post_rst_cnt", 32'(o_Count), 32'd0);

    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel, parametrised interval timer bank. It is the successor to the single 2 kHz two-second counter.
- Generates its own time-base tick from the system clock with an internal prescaler.
- Runs NUM_CH independent channels. Each channel has a runtime-loadable limit, one-shot or auto-reload mode, pause/resume, and an expiry pulse.
- Feeds the game FSM: dealer delay, display hold, and player timeout.

Parameters:
- WIDTH, 12, bit width of each channel count and limit.
- NUM_CH, 2, number of independent timer channels.
- PRESCALE, 25000, system clocks per tick (50 MHz to 2 kHz); must be ≥2.
- PS_W, 15, prescaler counter width; must satisfy 2**PS_W ≥ PRESCALE.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  reset; asynchronous assertion, active-low (0 = reset).
- i_Start  in  NUM_CH  per-channel start/resume strobe, 1-cycle pulse.
- i_Stop  in  NUM_CH  per-channel pause strobe.
- i_Clear  in  NUM_CH  per-channel clear strobe.
- i_Reload  in  NUM_CH  mode: 1 = auto-reload (periodic), 0 = one-shot; sampled at start.
- i_Limit  in  NUM_CH*WIDTH  per-channel terminal count; channel k occupies bits [k*WIDTH +: WIDTH].
- o_Count  out  NUM_CH*WIDTH  per-channel current count, same packing.
- o_Running  out  NUM_CH  1 while the channel is in RUN.
- o_Expired  out  NUM_CH  1-cycle pulse on each expiry.
- o_Done  out  NUM_CH  level, 1 while a one-shot channel sits in DONE.
- o_Tick  out  1  registered time-base tick, 1 cycle wide.

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - prescaler = 0, o_Tick = 0.
  - Every channel: state IDLE, count 0, latched limit 0, latched mode 0.
  - o_Running, o_Expired, o_Done all 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - o_Tick is registered high for exactly the one cycle following prescaler == PRESCALE-1, so the tick period is PRESCALE clocks.
  - Free-running: channel commands never affect it.
- Channel FSM states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority per channel, evaluated each cycle: Clear > Stop > Start > tick.
- Clear (any state): next state IDLE, count 0, o_Done 0. A tick or expiry in the same cycle is suppressed.
- Start:
  - From IDLE or DONE: latch i_Limit and i_Reload, count 0, enter RUN the next cycle.
  - From PAUSE: resume to RUN; limit, mode and count are not re-latched.
  - In RUN: ignored.
- Stop:
  - From RUN: go to PAUSE, count held.
  - From any other state: ignored.
- RUN, on a cycle with o_Tick=1:
  - If count == latched_limit-1, or latched_limit == 0: this is an expiry.
    - Next cycle o_Expired = 1 for one cycle.
    - Reload = 1: count to 0, stay in RUN.
    - Reload = 0: count to latched_limit, state DONE, o_Done = 1.
  - Otherwise: count increments by 1.
- Limit 0 expires on the first tick after start, and the count remains 0.
- Counting never wraps past 2**WIDTH-1. The maximum limit 2**WIDTH-1 is legal.
- Latency:
  - Start in cycle n gives o_Running = 1 in cycle n+1.
  - The first increment happens on the first tick seen in cycle n+1 or later. A tick coincident with Start is not counted.
- Changing i_Limit while in RUN has no effect until the next Start from IDLE or DONE.
- Channels are fully independent; identical stimulus gives identical per-channel timing.

Optional Feature:
- Macro: TIMER_TICK_BYPASS_EN.
- When defined:
  - The prescaler is not instantiated.
  - The internal tick is constant 1, so channels advance every clock.
  - o_Tick is driven 1 after reset release and 0 during reset.
  - Intended for fast Modelsim runs.
- When undefined: the PRESCALE time base operates as described above.

Test Plan:
- Prescaler (PRESCALE=4, reset released at cycle 0) -> o_Tick high at cycles 4, 8, 12; o_Count and channel outputs all 0 while idle.
- One-shot (ch0 limit=3, Reload=0, Start) -> count 1, 2, 3 on successive ticks; o_Expired pulses once; o_Done=1 and count=3 held; o_Running=0 afterwards.
- Auto-reload (ch1 limit=2, Reload=1) -> count sequence 0, 1, 0, 1...; o_Expired pulses every 2 ticks for 5 periods; o_Done never asserts.
- Pause/resume (ch0 limit=10: Stop at count 4, wait 5 ticks, Start) -> count holds 4 through the pause; o_Expired occurs 6 ticks after resume; the i_Limit change to 2 during the pause is ignored.
- Priority (Clear, Stop and Start asserted in the same cycle as an expiring tick) -> state IDLE, count 0, no o_Expired, o_Done 0.
- Async reset mid-run (i_Reset=0 between clock edges while count=5) -> all outputs 0 immediately; after release, channels stay IDLE until a Start.
